// File: rtl/bcd_countdown_if.sv
// bcd_countdown_if: control/status bundle between a controller and the BCD down-counter.
interface bcd_countdown_if #(parameter int DIGITS = 2);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  tick;
    logic                  abort;
    logic [4*DIGITS-1:0]   count;
    logic                  busy;
    logic                  timeout;
    logic                  load_err;
    modport master (output load, load_val, start, tick, abort, input count, busy, timeout, load_err);
    modport slave (input load, load_val, start, tick, abort, output count, busy, timeout, load_err);
endinterface

// File: rtl/bcd_countdown.sv
// bcd_countdown: loadable DIGITS-digit BCD down-counter with abort and one-cycle timeout strobe.
// Define BCD_COUNTDOWN_AUTO_RELOAD_EN to reload the preset on the terminal tick (periodic timer).
module bcd_countdown #(
    parameter int DIGITS = 2
) (
    input logic            CLK,
    input logic            RST,
    bcd_countdown_if.slave bus
);
    localparam int W = 4*DIGITS;
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_count, w_count_nxt, w_dec;
    logic         r_busy, r_timeout, r_load_err;
    logic         w_timeout_nxt, w_load_err_nxt, w_valid, w_borrow, w_is_zero, w_is_one;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    logic [W-1:0] r_reload, w_reload_nxt;
`endif
    assign w_is_zero = (r_count == '0);
    assign w_is_one  = (r_count == W'(1));
    // Borrow ripples upward through digits that are already zero, which wrap to 9.
    always_comb begin
        w_dec    = r_count;
        w_borrow = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_borrow)
                w_dec[4*d+:4] = (r_count[4*d+:4] == 4'd0) ? 4'd9 : r_count[4*d+:4] - 4'd1;
            w_borrow = w_borrow && (r_count[4*d+:4] == 4'd0);
        end
    end
    always_comb begin
        w_valid = 1'b1;
        for (int d = 0; d < DIGITS; d++)
            w_valid = w_valid && (bus.load_val[4*d+:4] <= 4'd9);
    end
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_timeout_nxt  = 1'b0;
        w_load_err_nxt = 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        w_reload_nxt   = r_reload;
`endif
        if (bus.abort) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end else if (bus.load) begin
            if (w_valid) begin
                w_state_nxt = ARMED;
                w_count_nxt = bus.load_val;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                w_reload_nxt = bus.load_val;
`endif
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (bus.start && r_state == ARMED) begin
            w_state_nxt   = w_is_zero ? DONE : RUN;
            w_timeout_nxt = w_is_zero;
        end else if (bus.tick && r_state == RUN) begin
            if (w_is_one) begin
                w_timeout_nxt = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                w_count_nxt   = r_reload;
`else
                w_count_nxt   = '0;
                w_state_nxt   = DONE;
`endif
            end else begin
                w_count_nxt = w_dec;
            end
        end
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_busy     <= (w_state_nxt == RUN);
            r_timeout  <= w_timeout_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_reload <= '0;
        else      r_reload <= w_reload_nxt;
    end
`endif
    assign bus.count    = r_count;
    assign bus.busy     = r_busy;
    assign bus.timeout  = r_timeout;
    assign bus.load_err = r_load_err;
endmodule
